// File: rtl/seg7_mux_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_mux_driver
// Brief    : Time-multiplexed hex 7-segment driver with blanking, leading-zero
//            suppression and frame-synchronous (tear-free) display updates.
// Revision : 1.0
// ============================================================================
module seg7_mux_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      lz_blank,
  input  logic                      load,
  output logic [6:0]                seg,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic                      frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0]            c_seg_off = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  c_dp_off  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] c_an_off  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [NUM_DIGITS-1:0] c_one     = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      c_cnt_tc  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      c_idx_tc  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_value;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_en;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_sh_value;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_en;
  logic [6:0]              r_seg;
  logic                    r_dp_out;
  logic [NUM_DIGITS-1:0]   r_anode;

  logic                    w_cnt_tc;
  logic                    w_idx_tc;
  logic                    w_frame;
  logic                    w_blank;
  logic                    w_all_zero;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [3:0]              w_nib;
  logic                    w_lit;
  logic [6:0]              w_pat;
  logic [NUM_DIGITS-1:0]   w_sel;

  function automatic logic [6:0] f_decode(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'b1111110;
      4'h1: p = 7'b0110000;
      4'h2: p = 7'b1101101;
      4'h3: p = 7'b1111001;
      4'h4: p = 7'b0110011;
      4'h5: p = 7'b1011011;
      4'h6: p = 7'b1011111;
      4'h7: p = 7'b1110000;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1111011;
      4'hA: p = 7'b1110111;
      4'hB: p = 7'b0011111;
      4'hC: p = 7'b1001110;
      4'hD: p = 7'b0111101;
      4'hE: p = 7'b1001111;
      default: p = 7'b1000111;
    endcase
    return p;
  endfunction

  assign w_cnt_tc   = (r_cnt == c_cnt_tc);
  assign w_idx_tc   = (r_idx == c_idx_tc);
  assign w_frame    = w_cnt_tc & w_idx_tc;
  assign frame_done = w_frame;

  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      assign w_blank = (r_cnt < CNT_W'(BLANK_CYCLES));
    end else begin : g_no_blank
      assign w_blank = 1'b0;
    end
  endgenerate

  // Walk from the most significant digit down; digit 0 is never suppressed.
  always_comb begin
    w_all_zero = 1'b1;
    w_lz       = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_all_zero = w_all_zero & (r_sh_value[4*i +: 4] == 4'h0);
      w_lz[i]    = lz_blank & w_all_zero;
    end
  end

  assign w_nib = r_sh_value[{r_idx, 2'b00} +: 4];
  assign w_lit = r_sh_en[r_idx] & ~w_lz[r_idx];
  assign w_pat = w_lit ? f_decode(w_nib) : 7'h00;
  assign w_sel = (w_lit & ~w_blank) ? (c_one << r_idx) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_cnt_tc) begin
      r_cnt <= '0;
      r_idx <= w_idx_tc ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A load in the boundary cycle is forwarded straight into the shadow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_en    <= '0;
      r_pend_valid <= 1'b0;
      r_sh_value   <= '0;
      r_sh_dp      <= '0;
      r_sh_en      <= '0;
    end else begin
      if (load) begin
        r_pend_value <= value;
        r_pend_dp    <= dp;
        r_pend_en    <= digit_en;
      end
      if (w_frame) begin
        r_pend_valid <= 1'b0;
        if (load) begin
          r_sh_value <= value;
          r_sh_dp    <= dp;
          r_sh_en    <= digit_en;
        end else if (r_pend_valid) begin
          r_sh_value <= r_pend_value;
          r_sh_dp    <= r_pend_dp;
          r_sh_en    <= r_pend_en;
        end
      end else if (load) begin
        r_pend_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_seg    <= c_seg_off;
      r_dp_out <= c_dp_off;
      r_anode  <= c_an_off;
    end else begin
      r_seg    <= SEG_ACTIVE_LOW ? ~w_pat : w_pat;
      r_dp_out <= SEG_ACTIVE_LOW ? ~(w_lit & r_sh_dp[r_idx]) : (w_lit & r_sh_dp[r_idx]);
      r_anode  <= AN_ACTIVE_LOW ? ~w_sel : w_sel;
    end
  end

  assign seg    = r_seg;
  assign dp_out = r_dp_out;
  assign anode  = r_anode;

endmodule
`default_nettype wire

// File: tb/tb_seg7_mux_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_mux_driver
// Brief    : Self-checking bench: slot-position reference model, vector table,
//            corner-case sequences and randomized loads.
// Revision : 1.0
// ============================================================================
module tb_seg7_mux_driver;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = N * DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  digit_en = '0;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  anode;
  logic        frame_done;

  seg7_mux_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .value(value), .dp(dp), .digit_en(digit_en),
    .lz_blank(lz_blank), .load(load), .seg(seg), .dp_out(dp_out),
    .anode(anode), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] pat [16];

  // Reference model: absolute position within the frame plus display/pending copies.
  int          m_pos;
  logic [15:0] m_sv, m_pv;
  logic [3:0]  m_sdp, m_sen, m_pdp, m_pen;
  logic        m_pvalid;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  d;
    logic [3:0]  e;
    logic        lz;
    logic [15:0] an;
    logic [27:0] sg;
    logic [3:0]  dpo;
  } vec_t;

  vec_t tab [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_out(input int pos, output logic [3:0] an,
                                    output logic [6:0] sg, output logic dpo);
    int   d;
    int   c;
    int   nib;
    logic lit;
    d   = pos / DIV;
    c   = pos % DIV;
    nib = int'((m_sv >> (4 * d)) & 16'hF);
    lit = m_sen[d] && !(lz_blank && d > 0 && (m_sv >> (4 * d)) == 16'h0);
    an  = (lit && c >= BLANK) ? ~(4'b0001 << d) : 4'hF;
    sg  = lit ? ~pat[nib] : 7'h7F;
    dpo = !(lit && m_sdp[d]);
  endfunction

  task automatic model_reset();
    m_pos = 0;
    m_sv = '0; m_pv = '0; m_sdp = '0; m_sen = '0; m_pdp = '0; m_pen = '0;
    m_pvalid = 1'b0;
  endtask

  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    model_out(m_pos, e_an, e_seg, e_dp);
    if (m_pos == FRAME - 1) begin
      if (load) begin
        m_sv = value; m_sdp = dp; m_sen = digit_en;
      end else if (m_pvalid) begin
        m_sv = m_pv; m_sdp = m_pdp; m_sen = m_pen;
      end
      m_pvalid = 1'b0;
    end else if (load) begin
      m_pv = value; m_pdp = dp; m_pen = digit_en;
      m_pvalid = 1'b1;
    end
    m_pos = (m_pos + 1) % FRAME;
    @(posedge clock);
    #1;
    check("anode", 32'(anode), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp_out", 32'(dp_out), 32'(e_dp));
    check("frame_done", 32'(frame_done), 32'(m_pos == FRAME - 1));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    value = v; dp = d; digit_en = e; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic to_pos(input int target);
    for (int k = 0; k < 2 * FRAME && m_pos != target; k++) step();
  endtask

  initial begin
    int last;
    int pulses;
    pat[0]  = 7'b1111110; pat[1]  = 7'b0110000; pat[2]  = 7'b1101101; pat[3]  = 7'b1111001;
    pat[4]  = 7'b0110011; pat[5]  = 7'b1011011; pat[6]  = 7'b1011111; pat[7]  = 7'b1110000;
    pat[8]  = 7'b1111111; pat[9]  = 7'b1111011; pat[10] = 7'b1110111; pat[11] = 7'b0011111;
    pat[12] = 7'b1001110; pat[13] = 7'b0111101; pat[14] = 7'b1001111; pat[15] = 7'b1000111;

    // Expected anode/seg packed as {digit3, digit2, digit1, digit0}, active-low.
    tab[0] = '{16'h12AF, 4'h0, 4'hF, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE}, {7'h4F, 7'h12, 7'h08, 7'h38}, 4'hF};
    tab[1] = '{16'h0000, 4'h0, 4'hF, 1'b1, {4'hF, 4'hF, 4'hF, 4'hE}, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'hF};
    tab[2] = '{16'h0050, 4'h0, 4'hF, 1'b1, {4'hF, 4'hF, 4'hD, 4'hE}, {7'h7F, 7'h7F, 7'h24, 7'h01}, 4'hF};
    tab[3] = '{16'h8421, 4'b0100, 4'b1011, 1'b0, {4'h7, 4'hF, 4'hD, 4'hE}, {7'h00, 7'h7F, 7'h12, 7'h4F}, 4'hF};
    tab[4] = '{16'hC0E0, 4'hF, 4'hF, 1'b1, {4'h7, 4'hB, 4'hD, 4'hE}, {7'h31, 7'h01, 7'h30, 7'h01}, 4'h0};
    tab[5] = '{16'h0009, 4'h1, 4'hF, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE}, {7'h01, 7'h01, 7'h01, 7'h04}, 4'hE};

    model_reset();
    #12;
    check("reset_anode", 32'(anode), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp", 32'(dp_out), 32'h1);
    check("reset_frame_done", 32'(frame_done), 32'h0);
    #10;
    reset = 1'b1;

    for (int t = 0; t < 6; t++) begin
      lz_blank = tab[t].lz;
      do_load(tab[t].v, tab[t].d, tab[t].e);
      for (int k = 0; k < FRAME && m_pos != 0; k++) step();
      for (int dg = 0; dg < N; dg++) begin
        for (int c = 0; c < DIV; c++) begin
          step();
          check("tab_anode", 32'(anode), (c < BLANK) ? 32'hF : 32'(tab[t].an[4*dg +: 4]));
          check("tab_seg", 32'(seg), 32'(tab[t].sg[7*dg +: 7]));
          check("tab_dp", 32'(dp_out), 32'(tab[t].dpo[dg]));
        end
      end
    end
    lz_blank = 1'b0;

    last = -1;
    pulses = 0;
    for (int cyc = 0; cyc < 3 * FRAME; cyc++) begin
      step();
      if (frame_done) begin
        if (last >= 0) check("fd_period", 32'(cyc - last), 32'(FRAME));
        last = cyc;
        pulses++;
      end
    end
    check("fd_count", 32'(pulses), 32'd3);

    to_pos(5);
    do_load(16'h1111, 4'h0, 4'hF);
    to_pos(9);
    do_load(16'h7654, 4'h0, 4'hF);
    to_pos(0);
    step();
    step();
    check("dbl_load_seg", 32'(seg), 32'h4C);
    check("dbl_load_an", 32'(anode), 32'hE);

    to_pos(FRAME - 1);
    do_load(16'h000B, 4'h0, 4'hF);
    step();
    step();
    check("coincident_seg", 32'(seg), 32'h60);

    to_pos(9);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_anode", 32'(anode), 32'hF);
    check("async_rst_seg", 32'(seg), 32'h7F);
    check("async_rst_fd", 32'(frame_done), 32'h0);
    model_reset();
    #1;
    reset = 1'b1;
    step();
    do_load(16'h0000, 4'h0, 4'hF);
    to_pos(0);
    step();
    check("post_rst_blank", 32'(anode), 32'hF);
    step();
    check("post_rst_anode", 32'(anode), 32'hE);
    check("post_rst_seg", 32'(seg), 32'h01);

    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [31:0] r;
        r        = $urandom;
        value    = r[15:0] >> (4 * $urandom_range(0, 4));
        dp       = 4'($urandom);
        digit_en = 4'($urandom);
        load     = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 31) == 0) lz_blank = ~lz_blank;
      step();
    end
    load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_mux_driver.md
Name: seg7_mux_driver

Overview:
- Time-multiplexed, parametrised hex display driver for N common-anode/cathode 7-segment digits on the board I/O path of the core.
- Accepts a packed vector of hex nibbles plus per-digit decimal-point and enable masks.
- Scans one digit per refresh slot with anti-ghosting blanking, optional leading-zero suppression and tear-free frame-synchronous updates.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; range 1..16.
- REFRESH_DIV, 100000, clock cycles per digit slot; minimum 2.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.
- SEG_ACTIVE_LOW, 1, 1 means seg/dp_out drive 0 to light a segment.
- AN_ACTIVE_LOW, 1, 1 means anode drives 0 to select a digit.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- value  in  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i]; digit 0 is least significant and rightmost.
- dp  in  NUM_DIGITS  decimal point request per digit.
- digit_en  in  NUM_DIGITS  1 = digit may light; 0 = forced blank.
- lz_blank  in  1  1 = suppress leading zeros.
- load  in  1  strobe; captures value/dp/digit_en into the pending register.
- seg  out  7  segments; seg[6]=a, seg[5]=b … seg[0]=g.
- dp_out  out  1  decimal point segment.
- anode  out  NUM_DIGITS  one-hot digit select.
- frame_done  out  1  one-cycle pulse at end of each full scan.

Behaviour:
- Reset (reset=0, async):
  - slot counter=0, digit index=0.
  - pending and shadow registers=0.
  - frame_done=0.
  - all anodes inactive; seg and dp_out unlit.
- Slot counter counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and the digit index increments.
  - The index wraps from NUM_DIGITS-1 to 0.
- frame_done is 1 for exactly the cycle in which counter=REFRESH_DIV-1 and index=NUM_DIGITS-1.
- load: pending captures value/dp/digit_en on any cycle with load=1; the last load before the boundary wins.
- Shadow update happens at the frame boundary (the same cycle frame_done=1): shadow <= pending if a load is outstanding, including a load in that same cycle, which is forwarded.
- Display always uses shadow, so no mixed old/new digits appear within a frame.
- Leading-zero blanking: with lz_blank=1, digit i is blanked if shadow nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked by this rule.
- Digit lit condition: digit_en[i]=1 and not LZ-blanked. A blanked digit keeps its anode inactive but still occupies its slot.
- dp lights only when the digit is lit and dp[i]=1.
- Anti-ghosting: while counter < BLANK_CYCLES, all anodes are inactive; seg and dp_out already carry the new digit's pattern.
- Outputs are registered: anode/seg/dp_out reflect the counter/index/shadow state of the previous cycle (1-cycle latency).
- Decode, active-high pattern a..g:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- Polarity: the pattern is inverted at the output when SEG_ACTIVE_LOW=1; anodes are inverted when AN_ACTIVE_LOW=1.
- NUM_DIGITS=1: index is constant 0, and frame_done pulses every REFRESH_DIV cycles.
- Reset asserted mid-slot: everything returns to reset values immediately. After release, scanning restarts at digit 0 with counter=0, showing zeros until the first load is followed by a frame boundary.

Test Plan:
- Config for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, both active-low.
- Reset then load value=16'h12AF, digit_en=4'hF, dp=0, after one frame boundary:
  - per slot, anode is 1111 for 1 cycle, then 1110/1101/1011/0111 for 3 cycles.
  - seg (active-low) is 0111000 (F), 0001000 (A), 0010010 (2), 1001111 (1).
- frame_done: pulses once every 16 cycles, exactly when index=3 and counter=3.
- Load value=16'h0000 with lz_blank=1: digits 3..1 stay anode-inactive; digit 0 shows 0000001. With value=16'h0050, digits 3 and 2 are blanked and digits 1 and 0 are lit.
- Load mid-frame, then a second load with a different value before the boundary: the old value is held until the boundary; the second value appears starting at digit 0. A load coincident with frame_done is adopted in that frame.
- dp=4'b0100, digit_en=4'b1011: digit 2 is never selected and dp_out stays unlit throughout; no other digit lights dp.
- Assert reset in the middle of slot 2: anode goes to 1111 and seg to 1111111 asynchronously. After release, the first selected anode is 1110, displaying 0.
